// File: rtl/rv32i_types.sv
// Shared core types: stall-cause indices and the stall counter read-port FSM states.
package rv32i_types;

    typedef enum logic [3:0] {
        RS_FULL           = 4'd0,
        BR_RS_FULL        = 4'd1,
        ALU_RS_FULL       = 4'd2,
        SQ_FULL           = 4'd3,
        LD_FULL           = 4'd4,
        FU_QUEUE_FULL     = 4'd5,
        MULT_BUSY         = 4'd6,
        DIV_BUSY          = 4'd7,
        FREE_LIST_EMPTY   = 4'd8,
        FETCH_QUEUE_EMPTY = 4'd9,
        ROB_FULL          = 4'd10,
        MEM_RS_FULL       = 4'd11,
        LSQ_FULL          = 4'd12,
        CDB_BUSY          = 4'd13,
        ICACHE_MISS       = 4'd14,
        DISPATCH_STALL    = 4'd15
    } stall_cause_e;

    localparam int NUM_STALL_CAUSES = 16;
    // The two aggregate counters sit directly after the per-cause ones.
    localparam int STALL_IDX_TOTAL  = NUM_STALL_CAUSES;
    localparam int STALL_IDX_ANY    = NUM_STALL_CAUSES + 1;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/stall_perf_counters_sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Clear wins; otherwise count up and stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/stall_perf_counters.sv
// Per-cause stall-cycle counter bank with snapshot shadow and a one-at-a-time read port.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   RD_IDLE | req_ready=1, waiting for a read request
//   RD_RESP | resp_valid=1, response registers held until resp_ready
module stall_perf_counters
    import rv32i_types::*;
#(
    parameter int NUM_CAUSES = NUM_STALL_CAUSES,
    parameter int CNT_WIDTH  = 32,
    parameter int IDX_W      = $clog2(NUM_CAUSES + 2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  count_en,
    input  logic [NUM_CAUSES-1:0] stall_vec,
    input  logic                  freeze,
    input  logic                  clear,
    input  logic                  snap,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [IDX_W-1:0]      req_idx,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [CNT_WIDTH-1:0]  resp_data,
    output logic                  resp_err
);

    localparam int NUM_CNT = NUM_CAUSES + 2;

    logic                 count_ok;
    logic [NUM_CNT-1:0]   inc_vec;
    logic [CNT_WIDTH-1:0] live   [NUM_CNT];
    logic [CNT_WIDTH-1:0] shadow [NUM_CNT];
    rd_state_e            state_q, state_d;
    logic                 accept;
    logic                 idx_err;
    logic [CNT_WIDTH-1:0] sel_data;

    assign count_ok = count_en & ~freeze;
    // Layout: causes, then total, then any-stall.
    assign inc_vec  = {count_ok & (|stall_vec), count_ok, stall_vec & {NUM_CAUSES{count_ok}}};

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_vec[g]),
            .clr   (clear),
            .count (live[g])
        );
    end

    // Shadow captures live values as they stood before this edge's update/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
        end else if (snap) begin
            for (int i = 0; i < NUM_CNT; i++) shadow[i] <= live[i];
        end
    end

    assign accept     = req_valid && (state_q == RD_IDLE);
    assign req_ready  = (state_q == RD_IDLE);
    assign resp_valid = (state_q == RD_RESP);

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= RD_IDLE;
        else
            state_q <= state_d;
    end

    // Read FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: if (req_valid)  state_d = RD_RESP;
            RD_RESP: if (resp_ready) state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    assign idx_err = (req_idx > IDX_W'(NUM_CNT - 1));

    // Shadow read mux; explicit compare keeps out-of-range indices off the array.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (req_idx == IDX_W'(i)) sel_data = shadow[i];
        end
    end

    // Response registers load only on accept, so a later snap cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else if (accept) begin
            resp_data <= idx_err ? '0 : sel_data;
            resp_err  <= idx_err;
        end
    end

endmodule

// File: tb/tb_stall_perf_counters.sv
// Randomized self-checking bench: a 32-bit and a 4-bit instance share stimulus and are
// compared against an unbounded-integer reference model saturated at read time.
module tb_stall_perf_counters;
    import rv32i_types::*;

    localparam int NC  = NUM_STALL_CAUSES;
    localparam int NCT = NC + 2;
    localparam int IW  = $clog2(NC + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          count_en = 1'b0;
    logic [NC-1:0] stall_vec = '0;
    logic          freeze = 1'b0;
    logic          clear = 1'b0;
    logic          snap = 1'b0;
    logic          req_valid = 1'b0;
    logic [IW-1:0] req_idx = '0;
    logic          resp_ready = 1'b0;

    logic          req_ready, resp_valid, resp_err;
    logic [31:0]   resp_data;
    logic          req_ready4, resp_valid4, resp_err4;
    logic [3:0]    resp_data4;

    int total = 0;
    int bad   = 0;

    longint mlive   [NCT];
    longint mshadow [NCT];

    always #5 clk = ~clk;

    stall_perf_counters #(.NUM_CAUSES(NC), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .count_en(count_en), .stall_vec(stall_vec),
        .freeze(freeze), .clear(clear), .snap(snap),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    stall_perf_counters #(.NUM_CAUSES(NC), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .count_en(count_en), .stall_vec(stall_vec),
        .freeze(freeze), .clear(clear), .snap(snap),
        .req_valid(req_valid), .req_ready(req_ready4), .req_idx(req_idx),
        .resp_valid(resp_valid4), .resp_ready(resp_ready),
        .resp_data(resp_data4), .resp_err(resp_err4)
    );

    // Reference model: plain integer counts, snapshot copies, clear beats increment.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCT; i++) begin
                mlive[i] = 0;
                mshadow[i] = 0;
            end
        end else begin
            if (snap)
                for (int i = 0; i < NCT; i++) mshadow[i] = mlive[i];
            if (clear) begin
                for (int i = 0; i < NCT; i++) mlive[i] = 0;
            end else if (count_en && !freeze) begin
                mlive[STALL_IDX_TOTAL]++;
                if (stall_vec != '0) mlive[STALL_IDX_ANY]++;
                for (int i = 0; i < NC; i++) if (stall_vec[i]) mlive[i]++;
            end
        end
    end

    function automatic longint sat(longint v, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic en, input logic [NC-1:0] vec, input logic frz,
                         input logic clr, input logic snp);
        count_en  = en;
        stall_vec = vec;
        freeze    = frz;
        clear     = clr;
        snap      = snp;
    endtask

    task automatic do_snap();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        tick(1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // One full read on both instances; hold = cycles with resp_ready low.
    task automatic do_read(input int idx, input int hold);
        longint e32, e4;
        logic   eerr;
        eerr = (idx > NCT - 1);
        e32  = eerr ? 0 : sat(mshadow[idx], 32);
        e4   = eerr ? 0 : sat(mshadow[idx], 4);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_idx   = IW'(idx);
        tick(1);
        req_valid = 1'b0;
        chk("resp_valid_set", resp_valid, 1);
        chk("req_ready_busy", req_ready, 0);
        repeat (hold) begin
            tick(1);
            chk("hold_data", resp_data, e32);
            chk("hold_valid", resp_valid, 1);
        end
        chk($sformatf("data32_idx%0d", idx), resp_data, e32);
        chk($sformatf("err_idx%0d", idx), resp_err, eerr);
        chk($sformatf("data4_idx%0d", idx), resp_data4, e4);
        chk($sformatf("err4_idx%0d", idx), resp_err4, eerr);
        chk("resp_valid4", resp_valid4, 1);
        resp_ready = 1'b1;
        tick(1);
        resp_ready = 1'b0;
        chk("resp_valid_drop", resp_valid, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    initial begin
        longint e_a, e_b;

        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);

        // Cause 0 for 10 cycles.
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        tick(10);
        do_snap();
        do_read(0, 0);
        do_read(1, 0);
        do_read(STALL_IDX_TOTAL, 0);
        do_read(STALL_IDX_ANY, 0);

        // Saturation on the 4-bit instance.
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick(1);
        drive(1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
        tick(20);
        do_snap();
        do_read(3, 0);
        do_read(STALL_IDX_TOTAL, 0);

        // snap and clear together, then two more cycles.
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick(1);
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(5);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        tick(1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        do_read(STALL_IDX_TOTAL, 0);
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick(2);
        do_snap();
        do_read(STALL_IDX_TOTAL, 0);

        // Freeze holds counts; freeze with clear zeroes them.
        drive(1'b1, 16'h00F0, 1'b0, 1'b0, 1'b0);
        tick(3);
        drive(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        tick(8);
        do_snap();
        do_read(4, 0);
        do_read(0, 0);
        do_read(STALL_IDX_ANY, 0);
        drive(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        tick(1);
        do_snap();
        do_read(4, 0);
        do_read(STALL_IDX_TOTAL, 0);

        // Long hold with a pending second request and a snap during RESP.
        drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        tick(4);
        do_snap();
        e_a = mshadow[1];
        req_valid = 1'b1;
        req_idx   = IW'(1);
        tick(1);
        req_idx = IW'(STALL_IDX_ANY);
        drive(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            snap = (c == 2);
            tick(1);
            chk("hold6_data", resp_data, e_a);
            chk("hold6_req_ready", req_ready, 0);
            chk("hold6_valid", resp_valid, 1);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        resp_ready = 1'b1;
        tick(1);
        resp_ready = 1'b0;
        chk("pend_not_yet_valid", resp_valid, 0);
        chk("pend_req_ready", req_ready, 1);
        e_b = mshadow[STALL_IDX_ANY];
        tick(1);
        req_valid = 1'b0;
        chk("pend_accept_valid", resp_valid, 1);
        chk("pend_accept_data", resp_data, e_b);
        resp_ready = 1'b1;
        tick(1);
        resp_ready = 1'b0;

        // Out-of-range indices.
        do_read(18, 0);
        do_read(31, 1);

        // Randomized phase.
        for (int it = 0; it < 40; it++) begin
            int n;
            n = $urandom_range(5, 15);
            for (int c = 0; c < n; c++) begin
                drive($urandom_range(0, 3) != 0, NC'($urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 7) == 0);
                tick(1);
            end
            if ((it % 4) == 0) begin
                drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
            end else begin
                drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
                tick(1);
                drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
            end
            do_read($urandom_range(0, 19), $urandom_range(0, 2));
            do_read($urandom_range(0, NCT - 1), 0);
        end

        // Asynchronous reset while a response is pending.
        drive(1'b1, 16'h8001, 1'b0, 1'b0, 1'b0);
        tick(3);
        do_snap();
        req_valid = 1'b1;
        req_idx   = IW'(STALL_IDX_TOTAL);
        tick(1);
        req_valid = 1'b0;
        chk("pre_rst_valid", resp_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", resp_valid, 0);
        chk("async_rst_req_ready", req_ready, 1);
        chk("async_rst_data", resp_data, 0);
        #1;
        rst = 1'b0;
        tick(1);
        do_snap();
        do_read(STALL_IDX_TOTAL, 0);
        do_read(0, 0);
        do_read(15, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
